// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam int XLEN    = 32;

  localparam logic [XLEN-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// In-order queue of fetched {pc, instr} entries with a single-cycle flush.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fetch_entry_t     wdata_i,
  output logic [CNT_W-1:0] count_o,
  output fetch_entry_t     head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok_s;
  logic             push_ok_s;

  // Guard against popping empty or pushing full-without-pop.
  always_comb begin
    pop_ok_s  = pop_i && (count_q != {CNT_W{1'b0}});
    push_ok_s = push_i && ((count_q < CNT_W'(DEPTH)) || pop_ok_s);
  end

  // Pointer, occupancy and storage next-state; flush wins over everything.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory and queues words for decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 4,
  parameter int              CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic [XLEN-1:0]     imem_addr,
  input  logic [INSTR_W-1:0]  imem_rd,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INSTR_W-1:0]  inst_out,
  output logic [XLEN-1:0]     inst_pc,
  output logic [CNT_W-1:0]    q_count
);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] count_s;
  logic             pop_s;
  logic             push_s;
  fetch_entry_t     wdata_s;
  fetch_entry_t     head_s;
  logic             unused_s;

  assign unused_s = ^redirect_pc[1:0];

  // Handshake: a full queue still accepts a push when the head leaves.
  always_comb begin
    pop_s          = (count_s != {CNT_W{1'b0}}) && inst_ready;
    push_s         = !redirect_valid && ((count_s < CNT_W'(DEPTH)) || pop_s);
    wdata_s.pc     = pc_q;
    wdata_s.instr  = imem_rd;
  end

  // PC next-state; redirect target is word-aligned, increment wraps mod 2^32.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (push_s) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (redirect_valid),
    .wdata_i (wdata_s),
    .count_o (count_s),
    .head_o  (head_s)
  );

  assign imem_addr  = pc_q;
  assign inst_valid = (count_s != {CNT_W{1'b0}});
  assign inst_out   = head_s.instr;
  assign inst_pc    = head_s.pc;
  assign q_count    = count_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stream, back-pressure, redirect, async reset, PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_out, inst_pc;
  logic [2:0]  q_count;

  logic [31:0] imem_addr2, imem_rd2, inst_out2, inst_pc2;
  logic        inst_valid2;
  logic [2:0]  q_count2;

  int total = 0;
  int bad   = 0;

  logic [31:0] rom [7];
  initial begin
    rom[0] = 32'h0062E233; rom[1] = 32'h00B67433; rom[2] = 32'h00B60433;
    rom[3] = 32'h41390433; rom[4] = 32'h015A4433; rom[5] = 32'h017B2433;
    rom[6] = 32'h0004A483;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd28) return rom[a[4:2]];
    else            return ~a;
  endfunction

  always_comb imem_rd  = mem_word(imem_addr);
  always_comb imem_rd2 = mem_word(imem_addr2);

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc), .q_count(q_count)
  );

  fetch_unit #(.RESET_PC(32'hFFFFFFF8), .DEPTH(4)) dut_wrap (
    .clk(clk), .rst(rst), .imem_addr(imem_addr2), .imem_rd(imem_rd2),
    .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
    .inst_valid(inst_valid2), .inst_ready(1'b1),
    .inst_out(inst_out2), .inst_pc(inst_pc2), .q_count(q_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #3;
    chk("rst_addr",      imem_addr,        32'h0);
    chk("rst_valid",     {31'h0, inst_valid}, 32'h0);
    chk("rst_count",     {29'h0, q_count}, 32'h0);
    chk("rst_out",       inst_out,         32'h0);
    chk("rst_pc",        inst_pc,          32'h0);
    chk("rst_wrap_addr", imem_addr2,       32'hFFFFFFF8);

    // Streaming with inst_ready held high.
    do_reset();
    step();
    chk("str_valid0", {31'h0, inst_valid}, 32'h1);
    chk("str_pc0",    inst_pc,  32'h0);
    chk("str_out0",   inst_out, 32'h0062E233);
    for (int i = 1; i < 7; i++) begin
      step();
      chk("str_valid", {31'h0, inst_valid}, 32'h1);
      chk("str_pc",    inst_pc,  32'(4 * i));
      chk("str_out",   inst_out, rom[i]);
    end

    // Asynchronous reset between edges with entries queued.
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'h0, inst_valid}, 32'h0);
    chk("arst_count", {29'h0, q_count}, 32'h0);
    chk("arst_addr",  imem_addr, 32'h0);

    // Back-pressure from release.
    inst_ready = 1'b0;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("bp_fill", {29'h0, q_count}, 32'(i));
    end
    chk("bp_addr", imem_addr, 32'h10);
    step();
    chk("bp_hold_count", {29'h0, q_count}, 32'h4);
    chk("bp_hold_addr",  imem_addr, 32'h10);
    chk("bp_hold_head",  inst_pc, 32'h0);
    inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("bp_drain_valid", {31'h0, inst_valid}, 32'h1);
      chk("bp_drain_pc",    inst_pc,  32'(4 * i));
      chk("bp_drain_out",   inst_out, rom[i]);
      step();
    end

    // Redirect to an unaligned target with three entries queued.
    inst_ready = 1'b0;
    do_reset();
    step(); step(); step();
    chk("rd_pre_count", {29'h0, q_count}, 32'h3);
    redirect_valid = 1'b1; redirect_pc = 32'h0000000A;
    step();
    redirect_valid = 1'b0;
    chk("rd_count", {29'h0, q_count}, 32'h0);
    chk("rd_valid", {31'h0, inst_valid}, 32'h0);
    chk("rd_addr",  imem_addr, 32'h8);
    step();
    chk("rd_valid1", {31'h0, inst_valid}, 32'h1);
    chk("rd_pc1",    inst_pc,  32'h8);
    chk("rd_out1",   inst_out, 32'h00B60433);

    // Full queue, pop and redirect in the same cycle.
    do_reset();
    step(); step(); step(); step();
    chk("fr_full", {29'h0, q_count}, 32'h4);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h00000017;
    chk("fr_head_before", inst_pc, 32'h0);
    step();
    redirect_valid = 1'b0;
    chk("fr_count", {29'h0, q_count}, 32'h0);
    chk("fr_valid", {31'h0, inst_valid}, 32'h0);
    chk("fr_addr",  imem_addr, 32'h14);
    step();
    chk("fr_pc_after",  inst_pc,  32'h14);
    chk("fr_out_after", inst_out, 32'h017B2433);

    // PC wrap on the second instance.
    do_reset();
    step();
    chk("wrap_pc0",  inst_pc2,  32'hFFFFFFF8);
    chk("wrap_out0", inst_out2, 32'h00000007);
    step();
    chk("wrap_pc1",  inst_pc2,  32'hFFFFFFFC);
    step();
    chk("wrap_pc2",  inst_pc2,  32'h00000000);
    chk("wrap_out2", inst_out2, 32'h0062E233);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
